fp_adder: RTL and testbench
===========================

// Module: fp_adder
// PURPOSE
//  Pipelined IEEE-754 single-precision floating-point adder, q = a + b.
//  Accumulator back end of the streaming reduction engine: one operand is the
//  running sum, the other is the per-element expression result.
//  Fully pipelined: accepts a new operand pair every cycle, fixed latency, no handshake.
// PARAMETERS
//  none; pipeline latency fixed at 3 clk cycles (internal localparam LATENCY = 3)
// PORTS
//  clk     in   1   clock, all state updates on rising edge
//  areset  in   1   reset, asynchronous, active-high; clears all pipeline regs and q
//  a       in   32  operand A, IEEE-754 binary32
//  b       in   32  operand B, IEEE-754 binary32
//  q       out  32  sum, registered, binary32
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous and active-high (areset).
//  - Reset: every stage register and q go to 32'h0000_0000 immediately on areset,
//    independent of clk; first valid q = 3 rising edges after release + valid inputs.
//  - Latency: inputs sampled at edge N appear on q after edge N+2 (3 register stages);
//    throughput 1/cycle; q holds f(a,b) of the sample 3 edges earlier, always.
//  - Stage 1: unpack; exp==0 -> operand treated as signed zero (denormals flushed);
//    swap so |X|>=|Y|; shift Y mantissa (hidden bit set) right by exp diff,
//    keeping guard, round, sticky; diff>=27 -> Y collapses to sticky only.
//  - Stage 2: effective add/sub on 27-bit extended mantissas (1 carry bit extra);
//    leading-zero count of the result.
//  - Stage 3: normalise (right 1 on carry, left by LZC), round-to-nearest-even
//    using G/R/S, renormalise on rounding carry, pack, apply specials.
//  - Sign: sign of larger-magnitude operand; exact cancellation -> +0;
//    (-0)+(-0) -> -0; (+0)+(-0) -> +0.
//  - Overflow (biased exp >= 255 after rounding) -> signed infinity.
//  - Underflow (result exp <= 0) -> signed zero (flush-to-zero output).
//  - NaN input, or +inf + -inf -> canonical quiet NaN 32'h7FC0_0000.
//  - inf + finite -> that inf; inf + same-sign inf -> that inf.
//  - No exception flags; no X propagation: q is never X after reset.
// TESTING
//  1) a=3F800000 (1.0), b=40000000 (2.0) -> q=40400000 exactly 3 edges later.
//  2) a=3FC00000, b=BFC00000 -> q=00000000; a=80000000, b=80000000 -> q=80000000.
//  3) Rounding: 3F800000+33800000 -> 3F800000 (tie, even);
//     3F800000+33C00000 -> 3F800001.
//  4) Specials: 7F7FFFFF+7F7FFFFF -> 7F800000; 7F800000+FF800000 -> 7FC00000;
//     00400000 (denormal)+3F800000 -> 3F800000.
//  5) Stream 100 random pairs back-to-back, one per cycle; compare each q
//     against a reference model (RNE, FTZ) delayed 3 cycles; zero mismatches.
//  6) Assert areset mid-stream between edges -> q=00000000 at once;
//     release -> correct results resume 3 edges after new inputs.

Source files
------------

// File: rtl/fp_adder.sv
// Three-stage pipelined binary32 adder (q = a + b), round-to-nearest-even,
// denormals flushed to zero on input and output, one operand pair per cycle.
module fp_adder (
  input  logic        clk,
  input  logic        areset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);

  typedef struct packed {
    logic        special;
    logic [31:0] spec_val;
    logic        zero_sign;
    logic        sign;
    logic        eff_sub;
    logic [7:0]  exp;
    logic [26:0] xm;
    logic [26:0] ym;
  } align_t;

  typedef struct packed {
    logic        special;
    logic [31:0] spec_val;
    logic        zero_sign;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] sum;
    logic [4:0]  lzc;
  } sum_t;

  align_t s1_d, s1_q;
  sum_t   s2_d, s2_q;
  logic [31:0] q_d;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  // Stage 1: classify, order by magnitude, align the smaller operand
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic [30:0] a_mag, b_mag, x_mag, y_mag;
  logic [23:0] y_sig;
  logic [7:0]  diff;
  logic [53:0] y_wide;

  always_comb begin
    // NOTE: every combinational output is given a default first so no path leaves it unassigned (no latch).
    s1_d   = '0;
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_mag  = a_zero ? 31'd0 : a[30:0];
    b_mag  = b_zero ? 31'd0 : b[30:0];
    swap   = (b_mag > a_mag);
    x_mag  = swap ? b_mag : a_mag;
    y_mag  = swap ? a_mag : b_mag;

    s1_d.sign      = swap ? b[31] : a[31];
    s1_d.eff_sub   = a[31] ^ b[31];
    s1_d.zero_sign = a_zero & b_zero & a[31] & b[31];
    s1_d.exp       = x_mag[30:23];
    s1_d.xm        = {|x_mag[30:23], x_mag[22:0], 3'b000};

    // Extended format: [26] hidden bit, [3] ulp, [2] guard, [1] round, [0] sticky
    y_sig  = {|y_mag[30:23], y_mag[22:0]};
    diff   = x_mag[30:23] - y_mag[30:23];
    y_wide = {y_sig, 30'd0} >> diff;
    if (diff >= 8'd27) s1_d.ym = {26'd0, |y_sig};
    else               s1_d.ym = {y_wide[53:28], |y_wide[27:0]};

    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
      s1_d.special  = 1'b1;
      s1_d.spec_val = 32'h7FC0_0000;
    end else if (a_inf) begin
      s1_d.special  = 1'b1;
      s1_d.spec_val = a;
    end else if (b_inf) begin
      s1_d.special  = 1'b1;
      s1_d.spec_val = b;
    end
  end

  // Stage 2: magnitude add/subtract; |X| >= |Y| keeps the difference non-negative
  always_comb begin
    s2_d           = '0;
    s2_d.special   = s1_q.special;
    s2_d.spec_val  = s1_q.spec_val;
    s2_d.zero_sign = s1_q.zero_sign;
    s2_d.sign      = s1_q.sign;
    s2_d.exp       = s1_q.exp;
    s2_d.sum       = s1_q.eff_sub ? ({1'b0, s1_q.xm} - {1'b0, s1_q.ym})
                                  : ({1'b0, s1_q.xm} + {1'b0, s1_q.ym});
    s2_d.lzc       = lzc27(s2_d.sum[26:0]);
  end

  // Stage 3: normalise, round to nearest even, pack and resolve specials
  logic [26:0]       norm;
  logic signed [9:0] e_norm, e_rnd;
  logic [23:0]       mant;
  logic              round_up;
  logic [24:0]       rnd;
  logic [22:0]       frac;

  always_comb begin
    if (s2_q.sum[27]) begin
      norm   = {s2_q.sum[27:2], s2_q.sum[1] | s2_q.sum[0]};
      e_norm = $signed({2'b00, s2_q.exp}) + 10'sd1;
    end else begin
      norm   = s2_q.sum[26:0] << s2_q.lzc;
      e_norm = $signed({2'b00, s2_q.exp}) - $signed({5'b00000, s2_q.lzc});
    end
    mant     = norm[26:3];
    round_up = norm[2] & (norm[1] | norm[0] | mant[0]);
    rnd      = {1'b0, mant} + {24'd0, round_up};
    e_rnd    = rnd[24] ? e_norm + 10'sd1 : e_norm;
    frac     = rnd[24] ? rnd[23:1] : rnd[22:0];

    if (s2_q.special)              q_d = s2_q.spec_val;
    else if (s2_q.sum == 28'd0)    q_d = {s2_q.zero_sign, 31'd0};
    else if (e_rnd >= 10'sd255)    q_d = {s2_q.sign, 8'hFF, 23'd0};
    else if (e_rnd <= 10'sd0)      q_d = {s2_q.sign, 31'd0};
    else                           q_d = {s2_q.sign, e_rnd[7:0], frac};
  end

  // NOTE: reset clears the whole pipeline so q can never present X after reset.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      s1_q <= '0;
      s2_q <= '0;
      q    <= 32'h0000_0000;
    end else begin
      // NOTE: non-blocking updates let every stage sample the previous stage's old value.
      s1_q <= s1_d;
      s2_q <= s2_d;
      q    <= q_d;
    end
  end

endmodule

// File: tb/tb_fp_adder.sv
// Self-checking bench for fp_adder: directed corner cases plus a random stream
// compared against a real-arithmetic reference delayed by the pipeline latency.
module tb_fp_adder;

  localparam int LATENCY = 3;

  logic        clk = 1'b0;
  logic        areset = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] q;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  fp_adder dut (
    .clk    (clk),
    .areset (areset),
    .a      (a),
    .b      (b),
    .q      (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  // Binary32 (already known finite, non-zero) widened exactly to a real
  function automatic real to_real(input logic [31:0] x);
    return $bitstoreal({x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0});
  endfunction

  // Reference: exact sum in double precision, then RNE to binary32 with FTZ
  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    logic        xn, yn, xi, yi, xz, yz, up;
    real         s;
    logic [63:0] bits;
    int          e;
    logic [23:0] keep;
    logic [28:0] rem;
    logic [24:0] k25;
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    if (xn || yn || (xi && yi && (x[31] != y[31]))) return 32'h7FC0_0000;
    if (xi) return x;
    if (yi) return y;
    xz = (x[30:23] == 8'h00);
    yz = (y[30:23] == 8'h00);
    if (xz && yz) return {x[31] & y[31], 31'd0};
    s = (xz ? 0.0 : to_real(x)) + (yz ? 0.0 : to_real(y));
    if (s == 0.0) return 32'h0000_0000;
    bits = $realtobits(s);
    e    = int'(bits[62:52]) - 1023 + 127;
    keep = {1'b1, bits[51:29]};
    rem  = bits[28:0];
    up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && keep[0]);
    k25  = {1'b0, keep} + 25'(up);
    if (k25[24]) begin
      e++;
      keep = k25[24:1];
    end else begin
      keep = k25[23:0];
    end
    if (e >= 255) return {bits[63], 8'hFF, 23'd0};
    if (e <= 0)   return {bits[63], 31'd0};
    return {bits[63], e[7:0], keep[22:0]};
  endfunction

  function automatic logic [31:0] special_val(input logic [2:0] sel);
    case (sel)
      3'd0:    return 32'h0000_0000;
      3'd1:    return 32'h8000_0000;
      3'd2:    return 32'h7F80_0000;
      3'd3:    return 32'hFF80_0000;
      3'd4:    return 32'h7FC0_0001;
      3'd5:    return 32'h0040_0000;
      3'd6:    return 32'h7F7F_FFFF;
      default: return 32'h0080_0000;
    endcase
  endfunction

  function automatic logic [31:0] rand_a();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) return special_val(r[2:0]);
    return r;
  endfunction

  // Second operand biased toward the interesting cases relative to the first
  function automatic logic [31:0] rand_b(input logic [31:0] x);
    logic [31:0] r;
    logic [7:0]  e;
    r = $urandom;
    case ($urandom_range(0, 7))
      0, 1:    return r;
      2:       return {~x[31], x[30:4], r[3:0]};
      3:       return {r[31], x[30:23], r[22:0]};
      4: begin
        e = x[30:23] + 8'(r[4:0]) - 8'd16;
        return {r[31], e, r[27:5]};
      end
      5:       return special_val(r[2:0]);
      6:       return {r[31], r[0] ? 8'hFE : 8'h01, r[23:1]};
      default: return r;
    endcase
  endfunction

  task automatic pop_check();
    check(tag_q.pop_front(), q, exp_q.pop_front());
  endtask

  // Drive one pair at a falling edge; check the pair issued LATENCY edges earlier
  task automatic push(input string tag, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] want);
    a = x;
    b = y;
    exp_q.push_back(want);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == LATENCY) pop_check();
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      @(posedge clk);
      @(negedge clk);
      pop_check();
    end
  endtask

  task automatic push_rand(input string prefix, input int idx);
    logic [31:0] x, y;
    x = rand_a();
    y = rand_b(x);
    push($sformatf("%s%0d_%08h_%08h", prefix, idx, x, y), x, y, ref_add(x, y));
  endtask

  initial begin
    areset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_q", q, 32'h0000_0000);
    a = 32'h3F80_0000;
    b = 32'h3F80_0000;
    repeat (3) @(negedge clk);
    check("reset_hold", q, 32'h0000_0000);
    a = 32'h0;
    b = 32'h0;
    areset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_zero", q, 32'h0000_0000);

    // Latency: result must appear on the third rising edge, not earlier
    a = 32'h3F80_0000;
    b = 32'h4000_0000;
    @(posedge clk); @(negedge clk);
    check("lat_edge1", q, 32'h0000_0000);
    @(posedge clk); @(negedge clk);
    check("lat_edge2", q, 32'h0000_0000);
    @(posedge clk); @(negedge clk);
    check("lat_edge3", q, 32'h4040_0000);

    push("cancel",      32'h3FC0_0000, 32'hBFC0_0000, 32'h0000_0000);
    push("negz_negz",   32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    push("posz_negz",   32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
    push("rne_tie",     32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    push("rne_up",      32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0001);
    push("overflow",    32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    push("inf_m_inf",   32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    push("denorm_in",   32'h0040_0000, 32'h3F80_0000, 32'h3F80_0000);
    push("inf_fin",     32'hFF80_0000, 32'h4120_0000, 32'hFF80_0000);
    push("inf_inf",     32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000);
    push("nan_in",      32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000);
    push("underflow",   32'h0080_0000, 32'h8080_0001, 32'h8000_0000);
    push("sub_norm",    32'h3F80_0000, 32'hBF7F_FFFF, 32'h3380_0000);
    drain();

    for (int i = 0; i < 100; i++) push_rand("rand", i);
    drain();

    // Asynchronous reset between clock edges, mid-stream
    for (int i = 0; i < 5; i++) push_rand("pre_rst", i);
    #2 areset = 1'b1;
    #1 check("rst_async", q, 32'h0000_0000);
    exp_q.delete();
    tag_q.delete();
    @(posedge clk); @(negedge clk);
    check("rst_edge", q, 32'h0000_0000);
    areset = 1'b0;
    for (int i = 0; i < 12; i++) push_rand("post_rst", i);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
